// File: rtl/regfile_scoreboard.sv
// Two-write, two-read register file with a per-register busy scoreboard for RAW hazard detection.
// Latency: reads, busy bits and busyCount are registered (1 cycle) with write-first bypass of same-edge updates.
// Backpressure: none; writes, reserves and reads are accepted every cycle.
module regfile_scoreboard #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 5,
    parameter int ZERO_REG  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDRWIDTH-1:0] readReg1,
    input  logic [ADDRWIDTH-1:0] readReg2,
    output logic [DATAWIDTH-1:0] readData1,
    output logic [DATAWIDTH-1:0] readData2,
    output logic                 readBusy1,
    output logic                 readBusy2,
    input  logic                 write0,
    input  logic [ADDRWIDTH-1:0] writeReg0,
    input  logic [DATAWIDTH-1:0] writeData0,
    input  logic                 write1,
    input  logic [ADDRWIDTH-1:0] writeReg1,
    input  logic [DATAWIDTH-1:0] writeData1,
    input  logic                 reserve,
    input  logic [ADDRWIDTH-1:0] reserveReg,
    output logic [ADDRWIDTH:0]   busyCount
);

    localparam int DEPTH = 2 ** ADDRWIDTH;
    localparam int CW    = ADDRWIDTH + 1;

    logic [DATAWIDTH-1:0] regs_q [DEPTH];
    logic [DATAWIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;

    logic [DATAWIDTH-1:0] read_data1_q, read_data1_d;
    logic [DATAWIDTH-1:0] read_data2_q, read_data2_d;
    logic                 read_busy1_q, read_busy1_d;
    logic                 read_busy2_q, read_busy2_d;
    logic [CW-1:0]        busy_count_q, busy_count_d;

    logic wr0_en;
    logic wr1_en;
    logic res_en;

    // Register 0 is never updated when hardwired, so reset keeps it at zero/idle.
    always_comb begin
        wr0_en = write0;
        wr1_en = write1;
        res_en = reserve;
        if (ZERO_REG != 0) begin
            if (writeReg0 == '0) wr0_en = 1'b0;
            if (writeReg1 == '0) wr1_en = 1'b0;
            if (reserveReg == '0) res_en = 1'b0;
        end
    end

    // Port 1 is applied after port 0 so it wins a same-address conflict;
    // the reserve is applied last because it represents the newer producer.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr0_en) begin
            regs_d[writeReg0] = writeData0;
            busy_d[writeReg0] = 1'b0;
        end
        if (wr1_en) begin
            regs_d[writeReg1] = writeData1;
            busy_d[writeReg1] = 1'b0;
        end
        if (res_en) begin
            busy_d[reserveReg] = 1'b1;
        end
    end

    always_comb begin
        read_data1_d = regs_d[readReg1];
        read_data2_d = regs_d[readReg2];
        read_busy1_d = busy_d[readReg1];
        read_busy2_d = busy_d[readReg2];
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_d = busy_count_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            read_data1_q <= '0;
            read_data2_q <= '0;
            read_busy1_q <= 1'b0;
            read_busy2_q <= 1'b0;
            busy_count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q       <= busy_d;
            read_data1_q <= read_data1_d;
            read_data2_q <= read_data2_d;
            read_busy1_q <= read_busy1_d;
            read_busy2_q <= read_busy2_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign readData1 = read_data1_q;
    assign readData2 = read_data2_q;
    assign readBusy1 = read_busy1_q;
    assign readBusy2 = read_busy2_q;
    assign busyCount = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one hardwired-zero instance and one ordinary-zero instance driven with identical stimulus.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  readReg1, readReg2;
    logic        write0, write1, reserve;
    logic [4:0]  writeReg0, writeReg1, reserveReg;
    logic [31:0] writeData0, writeData1;

    logic [31:0] z_rd1, z_rd2, n_rd1, n_rd2;
    logic        z_rb1, z_rb2, n_rb1, n_rb2;
    logic [5:0]  z_cnt, n_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATAWIDTH(32), .ADDRWIDTH(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(z_rd1), .readData2(z_rd2),
        .readBusy1(z_rb1), .readBusy2(z_rb2),
        .write0(write0), .writeReg0(writeReg0), .writeData0(writeData0),
        .write1(write1), .writeReg1(writeReg1), .writeData1(writeData1),
        .reserve(reserve), .reserveReg(reserveReg),
        .busyCount(z_cnt)
    );

    regfile_scoreboard #(.DATAWIDTH(32), .ADDRWIDTH(5), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(n_rd1), .readData2(n_rd2),
        .readBusy1(n_rb1), .readBusy2(n_rb2),
        .write0(write0), .writeReg0(writeReg0), .writeData0(writeData0),
        .write1(write1), .writeReg1(writeReg1), .writeData1(writeData1),
        .reserve(reserve), .reserveReg(reserveReg),
        .busyCount(n_cnt)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rr1, rr2;
        logic        w0;
        logic [4:0]  wr0;
        logic [31:0] wd0;
        logic        w1;
        logic [4:0]  wr1;
        logic [31:0] wd1;
        logic        res;
        logic [4:0]  resr;
        logic [31:0] e_rd1, e_rd2;
        logic        e_rb1, e_rb2;
        logic [5:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rr1, input logic [4:0] rr2,
                         input logic w0, input logic [4:0] wr0, input logic [31:0] wd0,
                         input logic w1, input logic [4:0] wr1, input logic [31:0] wd1,
                         input logic res, input logic [4:0] resr);
        @(negedge clk);
        rst = r; readReg1 = rr1; readReg2 = rr2;
        write0 = w0; writeReg0 = wr0; writeData0 = wd0;
        write1 = w1; writeReg1 = wr1; writeData1 = wd1;
        reserve = res; reserveReg = resr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] rr1, input logic [4:0] rr2);
        drive(1'b0, rr1, rr2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        rst = 1'b0; readReg1 = '0; readReg2 = '0;
        write0 = 1'b0; writeReg0 = '0; writeData0 = '0;
        write1 = 1'b0; writeReg1 = '0; writeData1 = '0;
        reserve = 1'b0; reserveReg = '0;

        //          rst  rr1 rr2 w0  wr0  wd0            w1  wr1  wd1           res  resr  e_rd1          e_rd2          rb1 rb2 cnt
        vecs[0]  = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b0, 5'd3, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h11,        1'b1, 5'd9, 32'h22, 1'b0, 5'd0,  32'h22,        32'h22,        1'b0, 1'b0, 6'd0};
        vecs[3]  = '{1'b0, 5'd5, 5'd6, 1'b1, 5'd5, 32'hA5,        1'b1, 5'd6, 32'h66, 1'b0, 5'd0,  32'hA5,        32'h66,        1'b0, 1'b0, 6'd0};
        vecs[4]  = '{1'b0, 5'd4, 5'd3, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b1, 5'd4,  32'h0,         32'hDEADBEEF,  1'b1, 1'b0, 6'd1};
        vecs[5]  = '{1'b0, 5'd4, 5'd4, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,         32'h0,         1'b1, 1'b1, 6'd1};
        vecs[6]  = '{1'b0, 5'd4, 5'd9, 1'b0, 5'd0, 32'h0,         1'b1, 5'd4, 32'h55, 1'b0, 5'd0,  32'h55,        32'h22,        1'b0, 1'b0, 6'd0};
        vecs[7]  = '{1'b0, 5'd8, 5'd8, 1'b1, 5'd8, 32'h88,        1'b0, 5'd0, 32'h0,  1'b1, 5'd8,  32'h88,        32'h88,        1'b1, 1'b1, 6'd1};
        vecs[8]  = '{1'b0, 5'd8, 5'd5, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b1, 5'd8,  32'h88,        32'hA5,        1'b1, 1'b0, 6'd1};
        vecs[9]  = '{1'b0, 5'd5, 5'd8, 1'b1, 5'd5, 32'h5A,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h5A,        32'h88,        1'b0, 1'b1, 6'd1};
        vecs[10] = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF,  1'b0, 5'd0, 32'h0,  1'b1, 5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 6'd1};
        vecs[11] = '{1'b0, 5'd8, 5'd10, 1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 32'h99, 1'b1, 5'd10, 32'h99,        32'h0,         1'b0, 1'b1, 6'd1};
        vecs[12] = '{1'b0, 5'd12, 5'd12, 1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0,  1'b1, 5'd12, 32'h0,         32'h0,         1'b1, 1'b1, 6'd2};
        vecs[13] = '{1'b1, 5'd9, 5'd12, 1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 32'h0,  1'b1, 5'd13, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0};
        vecs[14] = '{1'b0, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 6'd0};

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].rr1, vecs[i].rr2,
                  vecs[i].w0, vecs[i].wr0, vecs[i].wd0,
                  vecs[i].w1, vecs[i].wr1, vecs[i].wd1,
                  vecs[i].res, vecs[i].resr);
            check($sformatf("v%0d_rd1", i), z_rd1, vecs[i].e_rd1);
            check($sformatf("v%0d_rd2", i), z_rd2, vecs[i].e_rd2);
            check($sformatf("v%0d_rb1", i), 32'(z_rb1), 32'(vecs[i].e_rb1));
            check($sformatf("v%0d_rb2", i), 32'(z_rb2), 32'(vecs[i].e_rb2));
            check($sformatf("v%0d_cnt", i), 32'(z_cnt), 32'(vecs[i].e_cnt));
        end

        // Both instances are freshly reset here: write and reserve register 0 together.
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        check("zr_z_rd1", z_rd1, 32'h0);
        check("zr_z_rb1", 32'(z_rb1), 32'h0);
        check("zr_z_cnt", 32'(z_cnt), 32'h0);
        check("zr_n_rd1", n_rd1, 32'hFFFFFFFF);
        check("zr_n_rd2", n_rd2, 32'hFFFFFFFF);
        check("zr_n_rb1", 32'(n_rb1), 32'h1);
        check("zr_n_cnt", 32'(n_cnt), 32'h1);

        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
        check("zw_z_rd1", z_rd1, 32'h0);
        check("zw_n_rd1", n_rd1, 32'h1234);
        check("zw_n_rb1", 32'(n_rb1), 32'h0);
        check("zw_n_cnt", 32'(n_cnt), 32'h0);

        // Reserve every register: count saturates at DEPTH-1 with a hardwired zero, DEPTH without.
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a));
        end
        check("full_z_cnt", 32'(z_cnt), 32'd31);
        check("full_n_cnt", 32'(n_cnt), 32'd32);
        check("full_z_rb0", 32'(z_rb1), 32'h0);
        check("full_n_rb0", 32'(n_rb1), 32'h1);
        check("full_z_rb31", 32'(z_rb2), 32'h1);

        idle(5'd31, 5'd31);
        check("hold_n_cnt", 32'(n_cnt), 32'd32);

        drive(1'b1, 5'd31, 5'd0, 1'b1, 5'd31, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1);
        check("rst_n_cnt", 32'(n_cnt), 32'd0);
        check("rst_n_rb1", 32'(n_rb1), 32'h0);
        check("rst_n_rd1", n_rd1, 32'h0);

        idle(5'd31, 5'd1);
        check("post_n_rd1", n_rd1, 32'h0);
        check("post_n_rb2", 32'(n_rb2), 32'h0);
        check("post_z_cnt", 32'(z_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the single-write register file, for the pipelined core. Provides two write ports, two registered read ports with write-first bypass, and an optional hardwired zero register. Adds a per-register busy scoreboard: issue logic reserves destination registers and writeback releases them, so decode can detect RAW hazards from the same read.

Parameters:
DATAWIDTH, 32, width of each register and data port
ADDRWIDTH, 5, register address width; DEPTH = 2**ADDRWIDTH registers
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations; 0 = register 0 is ordinary

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
readReg1  input  ADDRWIDTH  read port 1 address
readReg2  input  ADDRWIDTH  read port 2 address
readData1  output  DATAWIDTH  registered read data, port 1
readData2  output  DATAWIDTH  registered read data, port 2
readBusy1  output  1  registered busy bit of readReg1
readBusy2  output  1  registered busy bit of readReg2
write0  input  1  write enable, port 0
writeReg0  input  ADDRWIDTH  write address, port 0
writeData0  input  DATAWIDTH  write data, port 0
write1  input  1  write enable, port 1
writeReg1  input  ADDRWIDTH  write address, port 1
writeData1  input  DATAWIDTH  write data, port 1
reserve  input  1  mark reserveReg busy (a producer has issued)
reserveReg  input  ADDRWIDTH  register to reserve
busyCount  output  ADDRWIDTH+1  registered count of busy registers

Behaviour:
- Reset (rst=1 at an edge): all registers 0, all busy bits 0, readData1/2=0, readBusy1/2=0, busyCount=0. Reset overrides all writes, reserves and reads in that cycle. Reset mid-operation discards pending reservations.
- Writes take effect at the rising edge when writeN=1.
- writeReg0==writeReg1 with both enabled: port 1 data wins.
- A write on either port clears the target's busy bit.
- reserve=1 sets the busy bit of reserveReg at the edge.
- Same register reserved and written in one cycle: data is written and the busy bit ends SET, because reserve wins as the newer producer.
- ZERO_REG=1: writes and reserves to address 0 are ignored. Register 0 always reads 0 with busy=0.
- Reads have 1-cycle latency. At edge k, readDataN and readBusyN capture the register contents and busy bit as they are after edge k's updates (write-first bypass). A write at edge k is therefore visible on readDataN immediately after edge k. This also applies to the busy set/clear at edge k.
- Both read ports may address the same register, and each returns the identical value.
- busyCount at edge k equals the population count of busy bits after edge k's updates. Range is 0..DEPTH, or 0..DEPTH-1 with ZERO_REG=1.
- Reserving an already-busy register is harmless: busy stays 1 and the count is unchanged. Writing a non-busy register leaves the count unchanged.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: write various registers, then assert rst for 1 cycle -> next edge: readData1/2=0, readBusy=0, busyCount=0. Reading reg 7 afterwards returns 0.
- Bypass: write0=1, writeReg0=3, writeData0=0xDEADBEEF, readReg1=3 in the same cycle -> readData1=0xDEADBEEF after that edge.
- Dual-write conflict: both ports write reg 9 with port0=0x11, port1=0x22 -> reg 9 reads 0x22. With different addresses (5 and 6), both values are retained.
- Scoreboard: reserve reg 4 -> readBusy1=1 (readReg1=4), busyCount=1. Two cycles later writeReg1=4, writeData1=0x55 -> readBusy1=0, readData1=0x55, busyCount=0.
- Reserve and write of reg 8 in the same cycle -> data is written, busy=1, busyCount increments by 1.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 and reserve reg 0 -> readData=0, readBusy=0, busyCount unchanged. Rerun with ZERO_REG=0 -> reads 0xFFFFFFFF, busy=1.
